// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the two-port regfile arbiter.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  localparam logic PORT_SPI = 1'b0;
  localparam logic PORT_LOC = 1'b1;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Combinational two-requester round-robin picker; the last-grant register lives in the parent.
module rr_arb2
  import regfile_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  // With both ports requesting, the port that did not win last time goes next.
  always_comb begin
    winner = last;
    if (req == 2'b01)      winner = PORT_SPI;
    else if (req == 2'b10) winner = PORT_LOC;
    else if (req == 2'b11) winner = ~last;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates the single-ported regfile between the SPI slave (port 0) and a local requester (port 1).
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              reg_cs,
  output logic              reg_wren,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output arb_state_t        state
);

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  logic       last;
  logic       cur;
  logic       winner;
  logic [1:0] cnt;

  rr_arb2 u_rr (
    .req    ({req1, req0}),
    .last   (last),
    .winner (winner)
  );

  // Bus and grant outputs are loaded on the IDLE->ISSUE edge so they are valid
  // exactly during the ISSUE cycle; reg_wren still holds the issued direction there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= PORT_LOC;
      cur       <= PORT_SPI;
      cnt       <= 2'd0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      reg_cs    <= 1'b0;
      reg_wren  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      reg_cs   <= 1'b0;
      reg_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            cur       <= winner;
            last      <= winner;
            reg_cs    <= 1'b1;
            reg_wren  <= (winner == PORT_LOC) ? we1 : we0;
            reg_addr  <= (winner == PORT_LOC) ? addr1 : addr0;
            reg_wdata <= (winner == PORT_LOC) ? wdata1 : wdata0;
            gnt0      <= (winner == PORT_SPI);
            gnt1      <= (winner == PORT_LOC);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (reg_wren) begin
            state <= IDLE;
          end else begin
            cnt   <= LAT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            if (cur == PORT_LOC) begin
              rdata1  <= reg_rdata;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= reg_rdata;
              rvalid0 <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3, each with a regfile model.
module tb_regfile_arbiter;
  import regfile_arb_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A (RD_LAT=1) ----------------
  logic          a_rst, a_req0, a_req1, a_we0, a_we1;
  logic [AW-1:0] a_addr0, a_addr1, a_reg_addr;
  logic [DW-1:0] a_wdata0, a_wdata1, a_rdata0, a_rdata1, a_reg_wdata, a_reg_rdata;
  logic          a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_reg_cs, a_reg_wren;
  arb_state_t    a_state;

  regfile_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(a_rst),
    .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0),
    .gnt0(a_gnt0), .rvalid0(a_rvalid0), .rdata0(a_rdata0),
    .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1),
    .gnt1(a_gnt1), .rvalid1(a_rvalid1), .rdata1(a_rdata1),
    .reg_cs(a_reg_cs), .reg_wren(a_reg_wren), .reg_addr(a_reg_addr),
    .reg_wdata(a_reg_wdata), .reg_rdata(a_reg_rdata), .state(a_state)
  );

  // ---------------- instance B (RD_LAT=3) ----------------
  logic          b_rst, b_req0, b_req1, b_we0, b_we1;
  logic [AW-1:0] b_addr0, b_addr1, b_reg_addr;
  logic [DW-1:0] b_wdata0, b_wdata1, b_rdata0, b_rdata1, b_reg_wdata, b_reg_rdata;
  logic          b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_reg_cs, b_reg_wren;
  arb_state_t    b_state;

  regfile_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(b_rst),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
    .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
    .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
    .reg_cs(b_reg_cs), .reg_wren(b_reg_wren), .reg_addr(b_reg_addr),
    .reg_wdata(b_reg_wdata), .reg_rdata(b_reg_rdata), .state(b_state)
  );

  // ---------------- regfile models ----------------
  // Read data is valid only in the cycle RD_LAT after cs; other cycles show a marker.
  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];
  logic [DW-1:0] pipe_a, pipe_b0, pipe_b1, pipe_b2;

  always @(posedge clk) begin
    if (a_reg_cs && a_reg_wren) mem_a[a_reg_addr] <= a_reg_wdata;
    pipe_a <= (a_reg_cs && !a_reg_wren) ? mem_a[a_reg_addr] : 32'hBAD0_0000;
    if (b_reg_cs && b_reg_wren) mem_b[b_reg_addr] <= b_reg_wdata;
    pipe_b0 <= (b_reg_cs && !b_reg_wren) ? mem_b[b_reg_addr] : 32'hBAD0_0001;
    pipe_b1 <= pipe_b0;
    pipe_b2 <= pipe_b1;
  end
  assign a_reg_rdata = pipe_a;
  assign b_reg_rdata = pipe_b2;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_qa0[$], exp_qa1[$], exp_qb0[$];
  logic [0:0]    exp_port_q[$];
  logic [DW-1:0] exp_mem_a [32];

  always @(negedge clk) begin
    logic [DW-1:0] e;
    checks++;
    if (a_gnt0 && a_gnt1) begin
      errors++;
      $display("FAIL a_both_gnt: gnt0=%b gnt1=%b, required at most one", a_gnt0, a_gnt1);
    end
    if (a_rvalid0) begin
      checks++;
      if (exp_qa0.size() == 0) begin
        errors++; $display("FAIL a_rvalid0_unexpected: rdata0=%h, no read pending", a_rdata0);
      end else begin
        e = exp_qa0.pop_front();
        if (a_rdata0 !== e) begin
          errors++; $display("FAIL a_rdata0: got %h expected %h", a_rdata0, e);
        end
      end
    end
    if (a_rvalid1) begin
      checks++;
      if (exp_qa1.size() == 0) begin
        errors++; $display("FAIL a_rvalid1_unexpected: rdata1=%h, no read pending", a_rdata1);
      end else begin
        e = exp_qa1.pop_front();
        if (a_rdata1 !== e) begin
          errors++; $display("FAIL a_rdata1: got %h expected %h", a_rdata1, e);
        end
      end
    end
    if (b_rvalid0 || b_rvalid1) begin
      checks++;
      if (b_rvalid1 || exp_qb0.size() == 0) begin
        errors++; $display("FAIL b_rvalid_unexpected: rvalid0=%b rvalid1=%b", b_rvalid0, b_rvalid1);
      end else begin
        e = exp_qb0.pop_front();
        if (b_rdata0 !== e) begin
          errors++; $display("FAIL b_rdata0: got %h expected %h", b_rdata0, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic a_access(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    int n;
    @(negedge clk);
    if (we) exp_mem_a[addr] = data;
    else if (port) exp_qa1.push_back(exp_mem_a[addr]);
    else exp_qa0.push_back(exp_mem_a[addr]);
    if (port) begin a_req1 = 1; a_we1 = we; a_addr1 = addr; a_wdata1 = data; end
    else      begin a_req0 = 1; a_we0 = we; a_addr0 = addr; a_wdata0 = data; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(port ? a_gnt1 : a_gnt0) && n < 20);
    checks++;
    if (!(port ? a_gnt1 : a_gnt0)) begin
      errors++; $display("FAIL a_access_gnt_timeout: port=%0d no gnt in %0d cycles", port, n);
    end
    a_req0 = 0; a_req1 = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    a_rst = 1; b_rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_rst = 0; b_rst = 0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_reg_cs, a_reg_wren} !== 6'b0 ||
          a_rdata0 !== '0 || a_rdata1 !== '0 || a_reg_addr !== '0 || a_reg_wdata !== '0) begin
        errors++;
        $display("FAIL reset_a: gnt=%b%b rv=%b%b cs=%b wren=%b rd0=%h rd1=%h addr=%h wd=%h, required all 0",
                 a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_reg_cs, a_reg_wren, a_rdata0, a_rdata1,
                 a_reg_addr, a_reg_wdata);
      end
      checks++;
      if ({b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_reg_cs, b_reg_wren} !== 6'b0 ||
          b_rdata0 !== '0 || b_reg_addr !== '0 || b_reg_wdata !== '0) begin
        errors++;
        $display("FAIL reset_b: gnt=%b%b rv=%b%b cs=%b wren=%b, required all 0",
                 b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_reg_cs, b_reg_wren);
      end
      checks++;
      if (a_state !== IDLE || b_state !== IDLE) begin
        errors++; $display("FAIL reset_state: a=%0d b=%0d required IDLE", a_state, b_state);
      end
    end
  endtask

  task automatic test_write_read();
    int n;
    @(negedge clk);
    a_req0 = 1; a_we0 = 1; a_addr0 = 5'h03; a_wdata0 = 32'hDEAD_BEEF;
    exp_mem_a[3] = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (!(a_gnt0 === 1 && a_gnt1 === 0 && a_reg_cs === 1 && a_reg_wren === 1 &&
          a_reg_addr === 5'h03 && a_reg_wdata === 32'hDEAD_BEEF)) begin
      errors++;
      $display("FAIL wr_issue: gnt0=%b cs=%b wren=%b addr=%h wd=%h, required 1 1 1 03 deadbeef",
               a_gnt0, a_reg_cs, a_reg_wren, a_reg_addr, a_reg_wdata);
    end
    a_req0 = 0;
    @(negedge clk);
    checks++;
    if (!(a_gnt0 === 0 && a_reg_cs === 0 && a_reg_wren === 0 && a_reg_addr === 5'h03 &&
          a_reg_wdata === 32'hDEAD_BEEF)) begin
      errors++;
      $display("FAIL wr_after: gnt0=%b cs=%b wren=%b addr=%h wd=%h, required 0 0 0 03 deadbeef",
               a_gnt0, a_reg_cs, a_reg_wren, a_reg_addr, a_reg_wdata);
    end
    a_req0 = 1; a_we0 = 0; a_addr0 = 5'h03;
    exp_qa0.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    n = 1;
    checks++;
    if (!(a_gnt0 === 1 && a_reg_cs === 1 && a_reg_wren === 0 && a_reg_addr === 5'h03)) begin
      errors++;
      $display("FAIL rd_issue: gnt0=%b cs=%b wren=%b addr=%h, required 1 1 0 03",
               a_gnt0, a_reg_cs, a_reg_wren, a_reg_addr);
    end
    a_req0 = 0;
    while (!a_rvalid0 && n < 12) begin @(negedge clk); n++; end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL rd_latency: rvalid0 at cycle %0d, required 3", n);
    end
    @(negedge clk);
    checks++;
    if (a_rvalid0 !== 0 || a_rdata0 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_hold: rvalid0=%b rdata0=%h, required 0 deadbeef", a_rvalid0, a_rdata0);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk); a_rst = 1;
    @(negedge clk); a_rst = 0;
    a_req0 = 1; a_we0 = 1; a_addr0 = 5'h01; a_wdata0 = 32'h1111_0001;
    a_req1 = 1; a_we1 = 1; a_addr1 = 5'h02; a_wdata1 = 32'h2222_0002;
    exp_mem_a[1] = 32'h1111_0001; exp_mem_a[2] = 32'h2222_0002;
    @(negedge clk);
    checks++;
    if (!(a_gnt0 === 1 && a_gnt1 === 0 && a_reg_addr === 5'h01)) begin
      errors++; $display("FAIL simul_first: gnt0=%b gnt1=%b addr=%h, required 1 0 01", a_gnt0, a_gnt1, a_reg_addr);
    end
    a_req0 = 0;
    @(negedge clk);
    checks++;
    if (a_gnt0 !== 0 || a_gnt1 !== 0) begin
      errors++; $display("FAIL simul_gap: gnt0=%b gnt1=%b, required 0 0", a_gnt0, a_gnt1);
    end
    @(negedge clk);
    checks++;
    if (!(a_gnt0 === 0 && a_gnt1 === 1 && a_reg_addr === 5'h02 && a_reg_wdata === 32'h2222_0002)) begin
      errors++;
      $display("FAIL simul_second: gnt0=%b gnt1=%b addr=%h wd=%h, required 0 1 02 22220002",
               a_gnt0, a_gnt1, a_reg_addr, a_reg_wdata);
    end
    a_req1 = 0;
  endtask

  task automatic test_fairness();
    int n, got, c0, c1, first_at, last_at;
    logic [0:0] e;
    @(negedge clk);
    for (int i = 0; i < 8; i++) exp_port_q.push_back(1'(i % 2));
    a_req0 = 1; a_we0 = 1; a_addr0 = 5'h04; a_wdata0 = 32'h0404_0404;
    a_req1 = 1; a_we1 = 1; a_addr1 = 5'h05; a_wdata1 = 32'h0505_0505;
    exp_mem_a[4] = 32'h0404_0404; exp_mem_a[5] = 32'h0505_0505;
    n = 0; got = 0; c0 = 0; c1 = 0; first_at = 0; last_at = 0;
    while (got < 8 && n < 40) begin
      @(negedge clk); n++;
      if (a_gnt0 || a_gnt1) begin
        e = exp_port_q.pop_front();
        checks++;
        if (a_gnt1 !== e) begin
          errors++; $display("FAIL fair_order: grant %0d went to port %0d, required %0d", got, a_gnt1, e);
        end
        if (a_gnt1) c1++; else c0++;
        if (got == 0) first_at = n;
        last_at = n;
        got++;
      end
    end
    a_req0 = 0; a_req1 = 0;
    checks++;
    if (c0 != 4 || c1 != 4) begin
      errors++; $display("FAIL fair_count: port0=%0d port1=%0d, required 4 4", c0, c1);
    end
    checks++;
    if (last_at - first_at != 14) begin
      errors++; $display("FAIL fair_rate: 8 grants spanned %0d cycles, required 14", last_at - first_at);
    end
    exp_port_q.delete();
  endtask

  task automatic test_back_to_back();
    int n, g1_at, rv1_at;
    @(negedge clk);
    a_req0 = 1; a_we0 = 0; a_addr0 = 5'h01;
    a_req1 = 1; a_we1 = 0; a_addr1 = 5'h02;
    exp_qa0.push_back(exp_mem_a[1]);
    exp_qa1.push_back(exp_mem_a[2]);
    n = 0; g1_at = 0; rv1_at = 0;
    while (rv1_at == 0 && n < 20) begin
      @(negedge clk); n++;
      if (a_gnt0) a_req0 = 0;
      if (a_gnt1) begin a_req1 = 0; g1_at = n; end
      if (a_rvalid1) rv1_at = n;
    end
    a_req0 = 0; a_req1 = 0;
    checks++;
    if (g1_at != 4 || rv1_at != 6) begin
      errors++; $display("FAIL b2b_timing: gnt1 at %0d rvalid1 at %0d, required 4 and 6", g1_at, rv1_at);
    end
  endtask

  task automatic test_random();
    logic          port, we;
    logic [AW-1:0] addr;
    for (int i = 0; i < 24; i++) begin
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = (i == 0) ? 5'h00 : (i == 1) ? 5'h1F : AW'($urandom_range(0, 31));
      a_access(port, we, addr, $urandom);
    end
  endtask

  task automatic test_latency();
    int n, cs_cnt;
    @(negedge clk);
    b_req0 = 1; b_we0 = 1; b_addr0 = 5'h1F; b_wdata0 = 32'hA5C3_0F1E;
    @(negedge clk);
    checks++;
    if (b_gnt0 !== 1 || b_reg_wren !== 1) begin
      errors++; $display("FAIL lat_wr_gnt: gnt0=%b wren=%b, required 1 1", b_gnt0, b_reg_wren);
    end
    b_req0 = 0;
    @(negedge clk);
    b_req0 = 1; b_we0 = 0; b_addr0 = 5'h1F;
    exp_qb0.push_back(32'hA5C3_0F1E);
    n = 0; cs_cnt = 0;
    do begin
      @(negedge clk); n++;
      if (b_reg_cs) cs_cnt++;
      if (b_gnt0) b_req0 = 0;
    end while (!b_rvalid0 && n < 15);
    b_req0 = 0;
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL lat_rvalid: rvalid0 at cycle %0d, required 5", n);
    end
    checks++;
    if (cs_cnt != 1) begin
      errors++; $display("FAIL lat_cs: reg_cs high %0d cycles, required 1", cs_cnt);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    @(negedge clk);
    b_req0 = 1; b_we0 = 0; b_addr0 = 5'h1F;
    exp_qb0.push_back(32'hA5C3_0F1E);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (b_gnt0) b_req0 = 0;
    end while (b_state !== WAIT && n < 10);
    checks++;
    if (b_state !== WAIT) begin
      errors++; $display("FAIL mid_wait: state=%0d, required WAIT", b_state);
    end
    b_rst = 1;
    @(negedge clk);
    exp_qb0.delete();
    b_rst = 0;
    checks++;
    if (b_state !== IDLE || b_rvalid0 !== 0 || b_rdata0 !== '0 || b_reg_cs !== 0 || b_gnt0 !== 0) begin
      errors++;
      $display("FAIL mid_reset: state=%0d rvalid0=%b rdata0=%h cs=%b gnt0=%b, required IDLE 0 0 0 0",
               b_state, b_rvalid0, b_rdata0, b_reg_cs, b_gnt0);
    end
    repeat (6) @(negedge clk);
    @(negedge clk);
    b_req0 = 1; b_we0 = 1; b_addr0 = 5'h00; b_wdata0 = 32'h0BAD_CAFE;
    @(negedge clk);
    checks++;
    if (b_gnt0 !== 1) begin
      errors++; $display("FAIL post_reset_wr: gnt0=%b, required 1", b_gnt0);
    end
    b_req0 = 0;
    @(negedge clk);
    b_req0 = 1; b_we0 = 0; b_addr0 = 5'h00;
    exp_qb0.push_back(32'h0BAD_CAFE);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (b_gnt0) b_req0 = 0;
    end while (!b_rvalid0 && n < 15);
    b_req0 = 0;
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL post_reset_rd: rvalid0 at cycle %0d, required 5", n);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    a_rst = 1; a_req0 = 0; a_req1 = 0; a_we0 = 0; a_we1 = 0;
    a_addr0 = '0; a_addr1 = '0; a_wdata0 = '0; a_wdata1 = '0;
    b_rst = 1; b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
    b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; exp_mem_a[i] = '0;
    end
    test_reset();
    test_write_read();
    test_simultaneous();
    test_fairness();
    test_back_to_back();
    test_random();
    test_latency();
    test_reset_mid_read();
    repeat (8) @(negedge clk);
    checks++;
    if (exp_qa0.size() != 0 || exp_qa1.size() != 0 || exp_qb0.size() != 0) begin
      errors++;
      $display("FAIL pending_reads: a0=%0d a1=%0d b0=%0d outstanding, required 0",
               exp_qa0.size(), exp_qa1.size(), exp_qb0.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
